alu_op_sequencer: RTL and testbench

Upstream command stage for the accumulator ALU. It accepts operation/operand commands over a valid/ready handshake and buffers them in a 4-entry FIFO. It issues one command per cycle on the ALU's `control`/`in` inputs, then captures the ALU accumulator and flags after the last command of a sequence and returns them over a second valid/ready handshake. It also clears the ALU accumulator after reset, because the ALU has no reset of its own.

---
 rtl/alu_op_sequencer_pkg.sv | 35 +++
 rtl/alu_op_sequencer_cmd_fifo.sv | 48 ++++
 rtl/alu_op_sequencer.sv | 117 +++++++++++
 tb/tb_alu_op_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// Shared constants for the ALU command sequencer: opcodes, FSM encoding, flag bit positions.
package alu_op_sequencer_pkg;

  typedef logic [2:0] alu_op_t;
  typedef logic [2:0] seq_state_t;

  // ALU instruction codes
  localparam alu_op_t OP_HOLD  = 3'd0;
  localparam alu_op_t OP_CLEAR = 3'd1;
  localparam alu_op_t OP_ADD   = 3'd2;
  localparam alu_op_t OP_SUB   = 3'd3;
  localparam alu_op_t OP_AND   = 3'd4;
  localparam alu_op_t OP_NEG   = 3'd5;
  localparam alu_op_t OP_NOT   = 3'd6;
  localparam alu_op_t OP_XOR   = 3'd7;

  // Sequencer FSM encoding
  localparam seq_state_t ST_INIT   = 3'd0;
  localparam seq_state_t ST_IDLE   = 3'd1;
  localparam seq_state_t ST_ISSUE  = 3'd2;
  localparam seq_state_t ST_WAIT   = 3'd3;
  localparam seq_state_t ST_RESULT = 3'd4;

  // Bit positions inside the 4-bit ALU flag vector
  localparam int unsigned FLAG_CARRY = 3;
  localparam int unsigned FLAG_ZERO  = 2;
  localparam int unsigned FLAG_OVF   = 1;
  localparam int unsigned FLAG_SIGN  = 0;

  // Only these opcodes consume the operand; the rest see alu_in = 0.
  function automatic logic op_has_operand(input alu_op_t op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_XOR);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_cmd_fifo.sv
// Command FIFO (cmd_fifo): registered storage, no fall-through, pointers with a wrap bit.
module alu_op_sequencer_cmd_fifo #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Full when indices match but the wrap bits differ
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; reset discards every queued entry
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Storage write; contents are only observed through a non-empty head
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command sequencer for the accumulator ALU: queues commands, issues one per cycle,
// and returns the accumulator/flags after the last command of each sequence.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [2:0]       i_cmd_op,
  input  logic [WIDTH-1:0] i_cmd_operand,
  input  logic             i_cmd_last,
  output logic [2:0]       o_alu_control,
  output logic [WIDTH-1:0] o_alu_in,
  input  logic [WIDTH-1:0] i_alu_acc,
  input  logic [3:0]       i_alu_flags,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [WIDTH-1:0] o_res_acc,
  output logic [3:0]       o_res_flags,
  output logic             o_busy
);

  // Entry layout: {op, operand, last}
  localparam int unsigned EW = WIDTH + 4;

  seq_state_t       r_state;
  seq_state_t       w_state_d;
  logic             r_res_valid;
  logic [WIDTH-1:0] r_res_acc;
  logic [3:0]       r_res_flags;

  logic [EW-1:0]    w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  alu_op_t          w_head_op;
  logic [WIDTH-1:0] w_head_operand;
  logic             w_head_last;

  assign w_head_op      = w_head[EW-1 -: 3];
  assign w_head_operand = w_head[WIDTH:1];
  assign w_head_last    = w_head[0];

  // Ready is held low while reset is asserted, even though the FIFO reads empty
  assign o_cmd_ready = i_rst_n && !w_full;
  assign w_push      = i_cmd_valid && o_cmd_ready;
  assign w_pop       = (r_state == ST_ISSUE) && !w_empty;

  alu_op_sequencer_cmd_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata ({i_cmd_op, i_cmd_operand, i_cmd_last}),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // ALU drive: CLEAR once after reset release, FIFO head while issuing, HOLD otherwise
  always_comb begin
    o_alu_control = OP_HOLD;
    o_alu_in      = '0;
    if ((r_state == ST_INIT) && i_rst_n) begin
      o_alu_control = OP_CLEAR;
    end else if (w_pop) begin
      o_alu_control = w_head_op;
      if (op_has_operand(w_head_op)) o_alu_in = w_head_operand;
    end
  end

  // Next-state logic; an empty FIFO inside ISSUE is a bubble, not an exit
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      ST_INIT:   w_state_d = ST_IDLE;
      ST_IDLE:   if (!w_empty) w_state_d = ST_ISSUE;
      ST_ISSUE:  if (w_pop && w_head_last) w_state_d = ST_WAIT;
      ST_WAIT:   w_state_d = ST_RESULT;
      ST_RESULT: if (r_res_valid && i_res_ready) w_state_d = ST_IDLE;
      default:   w_state_d = ST_IDLE;
    endcase
  end

  // State register and result capture at the end of WAIT
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_INIT;
      r_res_valid <= 1'b0;
      r_res_acc   <= '0;
      r_res_flags <= '0;
    end else begin
      r_state <= w_state_d;
      if (r_state == ST_WAIT) begin
        r_res_valid <= 1'b1;
        r_res_acc   <= i_alu_acc;
        r_res_flags <= i_alu_flags;
      end else if ((r_state == ST_RESULT) && i_res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign o_res_valid = r_res_valid;
  assign o_res_acc   = r_res_acc;
  assign o_res_flags = r_res_flags;
  assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer driving a behavioural accumulator ALU.
module tb_alu_op_sequencer;
  import alu_op_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic [7:0] cmd_operand = 8'h00;
  logic       cmd_last = 1'b0;
  logic [2:0] alu_control;
  logic [7:0] alu_in;
  logic [7:0] alu_acc;
  logic [3:0] alu_flags;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_acc;
  logic [3:0] res_flags;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [2:0] log_op[$];
  logic [7:0] log_in[$];
  int         log_cyc[$];

  alu_op_sequencer #(
    .WIDTH (8),
    .DEPTH (4)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_cmd_valid   (cmd_valid),
    .o_cmd_ready   (cmd_ready),
    .i_cmd_op      (cmd_op),
    .i_cmd_operand (cmd_operand),
    .i_cmd_last    (cmd_last),
    .o_alu_control (alu_control),
    .o_alu_in      (alu_in),
    .i_alu_acc     (alu_acc),
    .i_alu_flags   (alu_flags),
    .o_res_valid   (res_valid),
    .i_res_ready   (res_ready),
    .o_res_acc     (res_acc),
    .o_res_flags   (res_flags),
    .o_busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: no reset, flags {carry, zero, overflow, sign}
  function automatic logic [11:0] alu_next(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] b, input logic [3:0] f);
    logic [8:0] s;
    logic [7:0] r;
    logic       c;
    logic       v;
    c = 1'b0;
    v = 1'b0;
    r = a;
    case (op)
      OP_HOLD:  return {f, a};
      OP_CLEAR: return {4'b0100, 8'h00};
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[7:0];
        c = s[8];
        v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      OP_SUB: begin
        s = {1'b0, a} - {1'b0, b};
        r = s[7:0];
        c = s[8];
        v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      OP_AND: r = a & b;
      OP_NEG: begin
        r = 8'h00 - a;
        c = (a != 8'h00);
        v = (a == 8'h80);
      end
      OP_NOT: r = ~a;
      default: r = a ^ b;
    endcase
    return {c, (r == 8'h00), v, r[7], r};
  endfunction

  always @(posedge clk) {alu_flags, alu_acc} <= alu_next(alu_control, alu_acc, alu_in, alu_flags);

  // Log of every non-HOLD op presented to the ALU
  always @(negedge clk) begin
    if (rst_n && (alu_control !== OP_HOLD)) begin
      log_op.push_back(alu_control);
      log_in.push_back(alu_in);
      log_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic clear_log();
    log_op.delete();
    log_in.delete();
    log_cyc.delete();
  endtask

  task automatic push(input logic [2:0] op, input logic [7:0] operand, input logic last);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_operand = operand;
    cmd_last = last;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    cmd_last = 1'b0;
  endtask

  task automatic wait_res(output bit ok, output int at);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (res_valid === 1'b1) begin
        ok = 1'b1;
        at = cyc;
      end
    end
  endtask

  task automatic consume();
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready got %b exp 0", cmd_ready); end
    checks++; if (alu_control !== OP_HOLD) begin errors++; $display("FAIL rst_alu_control got %0d exp 0", alu_control); end
    checks++; if (alu_in !== 8'h00) begin errors++; $display("FAIL rst_alu_in got %h exp 00", alu_in); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid got %b exp 0", res_valid); end
    checks++; if (res_acc !== 8'h00) begin errors++; $display("FAIL rst_res_acc got %h exp 00", res_acc); end
    checks++; if (res_flags !== 4'h0) begin errors++; $display("FAIL rst_res_flags got %b exp 0000", res_flags); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy got %b exp 1", busy); end
    clear_log();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (alu_control !== OP_CLEAR) begin errors++; $display("FAIL init_clear got %0d exp 1", alu_control); end
    @(negedge clk);
    checks++; if (alu_control !== OP_HOLD) begin errors++; $display("FAIL idle_hold got %0d exp 0", alu_control); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", busy); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL idle_cmd_ready got %b exp 1", cmd_ready); end
    repeat (3) @(negedge clk);
    checks++; if (log_op.size() !== 1) begin errors++; $display("FAIL init_clear_count got %0d exp 1", log_op.size()); end
  endtask

  task automatic test_basic();
    bit ok;
    int at;
    clear_log();
    push(OP_ADD, 8'h05, 1'b0);
    push(OP_ADD, 8'h03, 1'b1);
    wait_res(ok, at);
    checks++; if (!ok) begin errors++; $display("FAIL basic_res_timeout got 0 exp 1"); end
    checks++; if (log_op.size() !== 2) begin errors++; $display("FAIL basic_issue_count got %0d exp 2", log_op.size()); end
    checks++; if (log_op[0] !== OP_ADD || log_in[0] !== 8'h05) begin errors++; $display("FAIL basic_op0 got %0d/%h exp 2/05", log_op[0], log_in[0]); end
    checks++; if (log_op[1] !== OP_ADD || log_in[1] !== 8'h03) begin errors++; $display("FAIL basic_op1 got %0d/%h exp 2/03", log_op[1], log_in[1]); end
    checks++; if (log_cyc[1] - log_cyc[0] != 1) begin errors++; $display("FAIL basic_issue_gap got %0d exp 1", log_cyc[1] - log_cyc[0]); end
    checks++; if (at - log_cyc[1] != 2) begin errors++; $display("FAIL basic_res_latency got %0d exp 2", at - log_cyc[1]); end
    checks++; if (res_acc !== 8'h08) begin errors++; $display("FAIL basic_acc got %h exp 08", res_acc); end
    checks++; if (res_flags !== 4'b0000) begin errors++; $display("FAIL basic_flags got %b exp 0000", res_flags); end
    consume();
    @(negedge clk);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL basic_res_clear got %b exp 0", res_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle got %b exp 0", busy); end
  endtask

  task automatic test_flags();
    bit ok;
    int at;
    clear_log();
    push(OP_CLEAR, 8'hAA, 1'b0);
    push(OP_ADD, 8'h7F, 1'b0);
    push(OP_ADD, 8'h01, 1'b1);
    wait_res(ok, at);
    checks++; if (log_op[0] !== OP_CLEAR || log_in[0] !== 8'h00) begin errors++; $display("FAIL clear_in_forced got %0d/%h exp 1/00", log_op[0], log_in[0]); end
    checks++; if (!ok || res_acc !== 8'h80) begin errors++; $display("FAIL ovf_acc got %h exp 80", res_acc); end
    checks++; if (res_flags !== 4'b0011) begin errors++; $display("FAIL ovf_flags got %b exp 0011", res_flags); end
    consume();
    push(OP_CLEAR, 8'h00, 1'b0);
    push(OP_SUB, 8'h01, 1'b1);
    wait_res(ok, at);
    checks++; if (!ok || res_acc !== 8'hFF) begin errors++; $display("FAIL borrow_acc got %h exp ff", res_acc); end
    checks++; if (res_flags !== 4'b1001) begin errors++; $display("FAIL borrow_flags got %b exp 1001", res_flags); end
    consume();
    push(OP_CLEAR, 8'h00, 1'b0);
    push(OP_ADD, 8'hFF, 1'b0);
    push(OP_ADD, 8'h01, 1'b1);
    wait_res(ok, at);
    checks++; if (!ok || res_acc !== 8'h00) begin errors++; $display("FAIL carry_acc got %h exp 00", res_acc); end
    checks++; if (res_flags !== 4'b1100) begin errors++; $display("FAIL carry_flags got %b exp 1100", res_flags); end
    consume();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int at;
    logic [4:0] rdy;
    logic [2:0] ops[5];
    logic [7:0] opd[5];
    ops = '{OP_ADD, OP_ADD, OP_XOR, OP_SUB, OP_ADD};
    opd = '{8'h01, 8'h02, 8'h0F, 8'h03, 8'h10};
    clear_log();
    push(OP_ADD, 8'h01, 1'b1);
    wait_res(ok, at);
    checks++; if (!ok || res_acc !== 8'h01) begin errors++; $display("FAIL b2b_pre_acc got %h exp 01", res_acc); end
    clear_log();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rdy[i] = cmd_ready;
      cmd_valid = 1'b1;
      cmd_op = ops[i];
      cmd_operand = opd[i];
      cmd_last = (i == 4);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      cmd_last = 1'b0;
    end
    checks++; if (rdy !== 5'b01111) begin errors++; $display("FAIL full_ready got %b exp 01111", rdy); end
    checks++; if (log_op.size() !== 0) begin errors++; $display("FAIL no_issue_in_result got %0d exp 0", log_op.size()); end
    consume();
    repeat (8) @(negedge clk);
    checks++; if (busy !== 1'b1 || alu_control !== OP_HOLD) begin errors++; $display("FAIL bubble got busy %b ctl %0d exp 1/0", busy, alu_control); end
    push(OP_ADD, 8'h20, 1'b1);
    wait_res(ok, at);
    checks++; if (log_op.size() !== 5) begin errors++; $display("FAIL drain_count got %0d exp 5", log_op.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (log_op[i] !== ops[i] || log_in[i] !== opd[i]) begin errors++; $display("FAIL drain_order%0d got %0d/%h exp %0d/%h", i, log_op[i], log_in[i], ops[i], opd[i]); end
    end
    for (int i = 1; i < 4; i++) begin
      checks++; if (log_cyc[i] - log_cyc[i-1] != 1) begin errors++; $display("FAIL drain_gap%0d got %0d exp 1", i, log_cyc[i] - log_cyc[i-1]); end
    end
    checks++; if (log_op[4] !== OP_ADD || log_in[4] !== 8'h20) begin errors++; $display("FAIL drain_tail got %0d/%h exp 2/20", log_op[4], log_in[4]); end
    checks++; if (!ok || res_acc !== 8'h28) begin errors++; $display("FAIL drain_acc got %h exp 28", res_acc); end
    checks++; if (res_flags !== 4'b0000) begin errors++; $display("FAIL drain_flags got %b exp 0000", res_flags); end
    consume();
  endtask

  task automatic test_hold();
    bit ok;
    int at;
    clear_log();
    push(OP_NOT, 8'h77, 1'b1);
    wait_res(ok, at);
    checks++; if (log_op[0] !== OP_NOT || log_in[0] !== 8'h00) begin errors++; $display("FAIL not_in_forced got %0d/%h exp 6/00", log_op[0], log_in[0]); end
    checks++; if (!ok || res_acc !== 8'hD7) begin errors++; $display("FAIL not_acc got %h exp d7", res_acc); end
    checks++; if (res_flags !== 4'b0001) begin errors++; $display("FAIL not_flags got %b exp 0001", res_flags); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (res_valid !== 1'b1 || res_acc !== 8'hD7 || res_flags !== 4'b0001 || alu_control !== OP_HOLD) begin
        errors++; $display("FAIL hold_stable%0d got %b/%h/%b/%0d exp 1/d7/0001/0", i, res_valid, res_acc, res_flags, alu_control);
      end
    end
    consume();
    #1;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL hold_handshake got %b exp 0", res_valid); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_idle got %b exp 0", busy); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int at;
    push(OP_ADD, 8'h05, 1'b1);
    wait_res(ok, at);
    push(OP_ADD, 8'h01, 1'b0);
    push(OP_ADD, 8'h02, 1'b0);
    push(OP_ADD, 8'h03, 1'b0);
    push(OP_ADD, 8'h04, 1'b0);
    consume();
    repeat (3) @(negedge clk);
    checks++; if (alu_control !== OP_ADD || alu_in !== 8'h02) begin errors++; $display("FAIL mid_issue got %0d/%h exp 2/02", alu_control, alu_in); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (res_valid !== 1'b0 || res_acc !== 8'h00) begin errors++; $display("FAIL mid_rst_res got %b/%h exp 0/00", res_valid, res_acc); end
    checks++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL mid_rst_ctrl got %b/%b exp 0/1", cmd_ready, busy); end
    checks++; if (alu_control !== OP_HOLD || alu_in !== 8'h00) begin errors++; $display("FAIL mid_rst_alu got %0d/%h exp 0/00", alu_control, alu_in); end
    clear_log();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (log_op.size() !== 1 || log_op[0] !== OP_CLEAR) begin errors++; $display("FAIL mid_no_stale got %0d ops first %0d exp 1/1", log_op.size(), log_op[0]); end
    checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL mid_idle got %b/%b exp 1/0", cmd_ready, busy); end
    push(OP_ADD, 8'h09, 1'b1);
    wait_res(ok, at);
    checks++; if (!ok || res_acc !== 8'h09 || res_flags !== 4'b0000) begin errors++; $display("FAIL mid_after got %h/%b exp 09/0000", res_acc, res_flags); end
    checks++; if (log_op.size() !== 2) begin errors++; $display("FAIL mid_after_count got %0d exp 2", log_op.size()); end
    consume();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flags();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
